// File: rtl/wb_pipe_reg_mc_if.sv
// Write-back pipeline register bundle: incoming write channels, stall/flush
// controls, the registered output stage and the forwarding lookup port.
interface wb_pipe_reg_mc_if #(
  parameter int CH = 2,
  parameter int AW = 5,
  parameter int DW = 32
);
  // pipeline control
  logic             i_stall;
  logic             i_flush;
  // incoming write bundle
  logic             i_valid;
  logic [CH-1:0]    i_regWe;
  logic [CH*AW-1:0] i_WRA;
  logic [CH*DW-1:0] i_WRD;
  // registered output stage (history entry 0)
  logic             o_valid;
  logic [CH-1:0]    o_regWe;
  logic [CH*AW-1:0] o_WRA;
  logic [CH*DW-1:0] o_rstW;
  // forwarding lookup
  logic [AW-1:0]    i_fwdA;
  logic             o_fwdHit;
  logic [DW-1:0]    o_fwdD;

  // upstream pipeline / bypass network side
  modport master (
    output i_stall, i_flush, i_valid, i_regWe, i_WRA, i_WRD, i_fwdA,
    input  o_valid, o_regWe, o_WRA, o_rstW, o_fwdHit, o_fwdD
  );

  // pipeline register side
  modport slave (
    input  i_stall, i_flush, i_valid, i_regWe, i_WRA, i_WRD, i_fwdA,
    output o_valid, o_regWe, o_WRA, o_rstW, o_fwdHit, o_fwdD
  );
endinterface

// File: rtl/wb_pipe_reg_mc.sv
// Multi-channel write-back pipeline register.
// Captures CH register writes per cycle, gates register-0 writes and
// same-cycle address conflicts (higher channel wins), and keeps a DEPTH-deep
// history of retired writes that feeds a combinational forwarding lookup.
// Entry 0 of the history is the live output stage.
module wb_pipe_reg_mc #(
  parameter int CH       = 2,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int DEPTH    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  wb_pipe_reg_mc_if.slave  bus
);

  // ---------------------------------------------------------------------
  // Effective write enables
  // ---------------------------------------------------------------------
  // A channel is a candidate when the bundle is valid, its enable is set and
  // it does not target register 0 (when register 0 is hardwired).
  logic [CH-1:0] cand;
  logic [CH-1:0] eff;
  // shadowed[k][j] is set when a higher channel j is a candidate for the
  // same address as channel k, which drops channel k.
  logic [CH-1:0] shadowed [CH];

  genvar gi, gj;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_cand
      logic addr_zero;
      assign addr_zero  = (bus.i_WRA[gi*AW +: AW] == '0);
      assign cand[gi]   = bus.i_valid & bus.i_regWe[gi] & ~(ZERO_REG & addr_zero);
    end

    for (gi = 0; gi < CH; gi++) begin : g_conf_row
      for (gj = 0; gj < CH; gj++) begin : g_conf_col
        if (gj > gi) begin : g_higher
          assign shadowed[gi][gj] = cand[gj] &
              (bus.i_WRA[gj*AW +: AW] == bus.i_WRA[gi*AW +: AW]);
        end else begin : g_lower
          assign shadowed[gi][gj] = 1'b0;
        end
      end
      assign eff[gi] = cand[gi] & ~(|shadowed[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // History storage
  // ---------------------------------------------------------------------
  logic             valid_q [DEPTH];
  logic [CH-1:0]    we_q    [DEPTH];
  logic [CH*AW-1:0] wra_q   [DEPTH];
  logic [CH*DW-1:0] wrd_q   [DEPTH];

  logic             valid_d [DEPTH];
  logic [CH-1:0]    we_d    [DEPTH];
  logic [CH*AW-1:0] wra_d   [DEPTH];
  logic [CH*DW-1:0] wrd_d   [DEPTH];

  // Next history: flush pushes a bubble, stall holds, otherwise the new
  // bundle enters entry 0; the oldest entry falls off the end.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      we_d[i]    = we_q[i];
      wra_d[i]   = wra_q[i];
      wrd_d[i]   = wrd_q[i];
    end
    if (bus.i_flush || !bus.i_stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        we_d[i]    = we_q[i-1];
        wra_d[i]   = wra_q[i-1];
        wrd_d[i]   = wrd_q[i-1];
      end
      if (bus.i_flush) begin
        valid_d[0] = 1'b0;
        we_d[0]    = '0;
        wra_d[0]   = '0;
        wrd_d[0]   = '0;
      end else begin
        // address and data are kept even for gated channels; only we matters
        valid_d[0] = bus.i_valid;
        we_d[0]    = eff;
        wra_d[0]   = bus.i_WRA;
        wrd_d[0]   = bus.i_WRD;
      end
    end
  end

  // History registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        we_q[i]    <= '0;
        wra_q[i]   <= '0;
        wrd_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        we_q[i]    <= we_d[i];
        wra_q[i]   <= wra_d[i];
        wrd_q[i]   <= wrd_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  assign bus.o_valid = valid_q[0];
  assign bus.o_regWe = we_q[0];
  assign bus.o_WRA   = wra_q[0];
  assign bus.o_rstW  = wrd_q[0];

  // ---------------------------------------------------------------------
  // Forwarding lookup over registered history only
  // ---------------------------------------------------------------------
  logic                query_zero;
  logic [DEPTH*CH-1:0] fwd_match;
  logic                fwd_hit;
  logic [DW-1:0]       fwd_data;

  assign query_zero = ZERO_REG & (bus.i_fwdA == '0);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fwd_ent
      for (gj = 0; gj < CH; gj++) begin : g_fwd_ch
        assign fwd_match[gi*CH + gj] = we_q[gi][gj] & ~query_zero &
            (wra_q[gi][gj*AW +: AW] == bus.i_fwdA);
      end
    end
  endgenerate

  // Priority select: scan oldest entry / lowest channel first so the newest
  // entry and highest channel overwrite and therefore win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      for (int k = 0; k < CH; k++) begin
        if (fwd_match[i*CH + k]) begin
          fwd_hit  = 1'b1;
          fwd_data = wrd_q[i][k*DW +: DW];
        end
      end
    end
  end

  assign bus.o_fwdHit = fwd_hit;
  assign bus.o_fwdD   = fwd_data;

endmodule
